// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: four shift modes, serial in/out, single step and counted burst.
// Optional build macro SHIFT_ARITH_EN turns mode 11 into arithmetic shift right instead of rotate right.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       step_mode;
  logic [WIDTH:0]   step_res;

  // Result packed as {bit shifted out, new register value}.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] v,
                                                input logic [1:0] m,
                                                input logic s);
    logic [WIDTH:0] r;
    case (m)
      2'b00:   r = {v[WIDTH-1], v[WIDTH-2:0], s};
      2'b01:   r = {v[0], s, v[WIDTH-1:1]};
      2'b10:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
`ifdef SHIFT_ARITH_EN
      default: r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
`else
      default: r = {v[0], v[0], v[WIDTH-1:1]};
`endif
    endcase
    return r;
  endfunction

  // A running burst keeps the mode captured at start; single steps follow the live input.
  assign step_mode = (state_q == RUN) ? mode_q : mode;
  assign step_res  = shift_step(data_q, step_mode, sin);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (load) begin
      data_d  = d;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (amount != '0) begin
              cnt_d   = amount;
              mode_d  = mode;
              state_d = RUN;
            end else begin
              state_d = DONE;
            end
          end else if (en) begin
            data_d = step_res[WIDTH-1:0];
            sout_d = step_res[WIDTH];
          end
        end
        RUN: begin
          data_d = step_res[WIDTH-1:0];
          sout_d = step_res[WIDTH];
          cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign q    = data_q;
  assign sout = sout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
